// File: rtl/cdc_stream_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : cdc_stream_tx_if
//  Brief    : Port bundle for cdc_stream_tx. It carries the producer stream
//             (valid/ready/data), the seq/ack toggle channel toward the
//             remote receiver, and the level/idle status.
//  Revision : 1.0 - initial release
// ============================================================================
interface cdc_stream_tx_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int c_LVL_W = $clog2(DEPTH) + 1;

  // producer side
  logic               in_valid;
  logic [WIDTH-1:0]   in_data;
  logic               in_ready;

  // toggle channel (tx_ack is already synchronized into the local clock)
  logic [WIDTH-1:0]   tx_value;
  logic               tx_seq;
  logic               tx_ack;

  // status
  logic [c_LVL_W-1:0] level;
  logic               idle;

  // Seen from the transmitter block.
  modport slave (
    input  in_valid, in_data, tx_ack,
    output in_ready, tx_value, tx_seq, level, idle
  );

  // Seen from the surrounding logic (producer plus synchronized receiver ack).
  modport master (
    output in_valid, in_data, tx_ack,
    input  in_ready, tx_value, tx_seq, level, idle
  );
endinterface
`default_nettype wire

// File: rtl/cdc_stream_tx.sv
`default_nettype none
// ============================================================================
//  Module   : cdc_stream_tx
//  Brief    : Source-domain end of a seq/ack toggle clock-domain crossing.
//             Words arrive on a valid/ready port and are held in a small
//             FIFO. One word at a time is launched by loading tx_value and
//             toggling tx_seq. The next launch waits until the synchronized
//             tx_ack matches tx_seq again.
//  Revision : 1.0 - initial release
// ============================================================================
module cdc_stream_tx #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  wire logic        clk,
  input  wire logic        rst,
  cdc_stream_tx_if.slave   bus
);

  localparam int                 c_ADDR_W = $clog2(DEPTH);
  localparam int                 c_LVL_W  = c_ADDR_W + 1;
  localparam logic [c_LVL_W-1:0] c_FULL   = c_LVL_W'(DEPTH);
  localparam logic [c_ADDR_W-1:0] c_PTR_ONE = c_ADDR_W'(1);
  localparam logic [c_LVL_W-1:0]  c_LVL_ONE = c_LVL_W'(1);

  // --------------------------------------------------------------------------
  // Storage and state
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [c_ADDR_W-1:0] r_wr_ptr;
  logic [c_ADDR_W-1:0] r_rd_ptr;
  logic [c_LVL_W-1:0]  r_level;

  // tx_seq and tx_value are deliberately outside the reset domain. A word
  // already handed to the far side cannot be withdrawn, so reset must not
  // re-toggle the channel or tear the value the receiver may be sampling.
  // They start at zero on power-up and are then only updated by launches.
  logic                r_tx_seq   = 1'b0;
  logic [WIDTH-1:0]    r_tx_value = '0;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic w_full;
  logic w_empty;
  logic w_chan_free;
  logic w_push;
  logic w_pop;

  // Fullness alone gates the producer. A same-cycle pop does not make room
  // until the following cycle, which keeps in_ready free of any tx_ack path.
  assign w_full      = (r_level == c_FULL);
  assign w_empty     = (r_level == '0);

  // The channel is free once the receiver has echoed the last toggle. A
  // spurious ack edge also makes these differ. That case is handled as an
  // outstanding transfer and waits until they match again.
  assign w_chan_free = (r_tx_seq == bus.tx_ack);

  assign w_push      = bus.in_valid && !w_full && !rst;

  // Emptiness is taken from the registered level. A word pushed in this
  // cycle therefore launches at the next edge at the earliest (no bypass).
  assign w_pop       = w_chan_free && !w_empty && !rst;

  // --------------------------------------------------------------------------
  // FIFO data array: write only, no reset needed on the payload
  // --------------------------------------------------------------------------
  // Capture accepted producer words at the write pointer.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.in_data;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // --------------------------------------------------------------------------
  // Pointers wrap modulo DEPTH. A separate level counter tells full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_LVL_ONE;
        2'b01:   r_level <= r_level - c_LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Launch register
  // --------------------------------------------------------------------------
  // On a launch, load the head word and flip seq in the same edge, so the
  // receiver never sees a new toggle with a stale value. The pop signal is
  // already masked by rst, so a launch cannot happen during reset.
  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_tx_value <= r_mem[r_rd_ptr];
      r_tx_seq   <= !bus.tx_ack;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.in_ready = !w_full;
  assign bus.tx_value = r_tx_value;
  assign bus.tx_seq   = r_tx_seq;
  assign bus.level    = r_level;
  // idle is the only output that looks combinationally at tx_ack.
  assign bus.idle     = w_empty && w_chan_free;

endmodule
`default_nettype wire

// File: tb/tb_cdc_stream_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cdc_stream_tx
//  Brief    : Self-checking bench for cdc_stream_tx (WIDTH=8, DEPTH=4).
//             A vector table covers the single-word and backpressure
//             scenarios. Hand sequences cover random streaming, push/pop at
//             level 2, and reset with a transfer in flight or a full FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cdc_stream_tx;

  localparam int c_W = 8;
  localparam int c_D = 4;
  localparam int c_N = 50;

  logic clk = 1'b0;
  logic rst;

  cdc_stream_tx_if #(.WIDTH(c_W), .DEPTH(c_D)) bus ();

  cdc_stream_tx #(.WIDTH(c_W), .DEPTH(c_D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [7:0] data;
    logic       ack;
    logic       rdy;
    logic [7:0] val;
    logic       seq;
    logic [2:0] lvl;
    logic       idl;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic v, input logic [7:0] d,
                              input logic a, input logic rd, input logic [7:0] tv,
                              input logic s, input logic [2:0] l, input logic i);
    vec_t x;
    x.rst = r; x.vld = v; x.data = d; x.ack = a;
    x.rdy = rd; x.val = tv; x.seq = s; x.lvl = l; x.idl = i;
    tbl.push_back(x);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs, advance one edge, and leave the bench 1 time unit after it.
  task automatic cyc(input logic r, input logic v, input logic [7:0] d, input logic a);
    rst          = r;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.tx_ack   = a;
    @(posedge clk);
    #1;
  endtask

  task automatic exp5(input string tag, input logic rd, input logic [7:0] tv,
                      input logic s, input logic [2:0] l, input logic i);
    chk({tag, ".in_ready"}, bus.in_ready, rd);
    chk({tag, ".tx_value"}, bus.tx_value, tv);
    chk({tag, ".tx_seq"},   bus.tx_seq,   s);
    chk({tag, ".level"},    bus.level,    l);
    chk({tag, ".idle"},     bus.idle,     i);
  endtask

  // Random-stream state
  logic [7:0] sent[$];
  logic [7:0] got[$];

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.tx_ack   = 1'b0;

    // ---------------- table: single word, then fill/backpressure ----------
    //   rst vld data  ack | rdy val  seq lvl idle
    add(1, 0, 8'h00, 0,   1, 8'h00, 0, 0, 1);
    add(0, 1, 8'hA5, 0,   1, 8'h00, 0, 1, 0);
    add(0, 0, 8'h00, 0,   1, 8'hA5, 1, 0, 0);
    for (int k = 0; k < 10; k++) add(0, 0, 8'h00, 0, 1, 8'hA5, 1, 0, 0);
    add(0, 0, 8'h00, 1,   1, 8'hA5, 1, 0, 1);
    // channel free with ack=1; stream 01..06
    add(0, 1, 8'h01, 1,   1, 8'hA5, 1, 1, 0);
    add(0, 1, 8'h02, 1,   1, 8'h01, 0, 1, 0);
    add(0, 1, 8'h03, 1,   1, 8'h01, 0, 2, 0);
    add(0, 1, 8'h04, 1,   1, 8'h01, 0, 3, 0);
    add(0, 1, 8'h05, 1,   0, 8'h01, 0, 4, 0);
    add(0, 1, 8'h06, 1,   0, 8'h01, 0, 4, 0);
    add(0, 1, 8'h06, 1,   0, 8'h01, 0, 4, 0);
    add(0, 1, 8'h06, 0,   1, 8'h02, 1, 3, 0);
    add(0, 1, 8'h06, 0,   0, 8'h02, 1, 4, 0);
    // drain with ack toggles
    add(0, 0, 8'h00, 1,   1, 8'h03, 0, 3, 0);
    add(0, 0, 8'h00, 0,   1, 8'h04, 1, 2, 0);
    add(0, 0, 8'h00, 1,   1, 8'h05, 0, 1, 0);
    add(0, 0, 8'h00, 0,   1, 8'h06, 1, 0, 0);
    add(0, 0, 8'h00, 1,   1, 8'h06, 1, 0, 1);

    foreach (tbl[i]) begin
      cyc(tbl[i].rst, tbl[i].vld, tbl[i].data, tbl[i].ack);
      exp5($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].val, tbl[i].seq,
           tbl[i].lvl, tbl[i].idl);
    end

    // ---------------- random stream with random ack delays ----------------
    for (int i = 0; i < c_N; i++) sent.push_back(8'($urandom_range(0, 255)));
    fork
      begin : producer
        logic acc;
        int   budget;
        for (int i = 0; i < c_N; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
          end
          bus.in_valid = 1'b1;
          bus.in_data  = sent[i];
          acc    = 1'b0;
          budget = 200;
          while (!acc && budget > 0) begin
            acc = bus.in_ready;
            @(posedge clk); #1;
            budget--;
          end
          if (!acc) begin
            chk("rand.push_timeout", 32'd0, 32'd1);
            break;
          end
        end
        bus.in_valid = 1'b0;
      end
      begin : receiver
        logic       pending;
        logic [7:0] cap;
        int         dly;
        int         budget;
        pending = 1'b0;
        cap     = '0;
        dly     = 0;
        budget  = 3000;
        while (got.size() < c_N && budget > 0) begin
          @(posedge clk); #1;
          budget--;
          if (bus.tx_seq != bus.tx_ack) begin
            if (!pending) begin
              pending = 1'b1;
              cap     = bus.tx_value;
              got.push_back(cap);
              dly     = $urandom_range(0, 7);
            end else begin
              chk("rand.tx_value_stable", bus.tx_value, cap);
            end
            if (dly == 0) begin
              bus.tx_ack = bus.tx_seq;
              pending    = 1'b0;
            end else begin
              dly--;
            end
          end
        end
        bus.tx_ack = bus.tx_seq;
      end
    join
    chk("rand.count", got.size(), c_N);
    for (int i = 0; i < c_N && i < got.size(); i++)
      chk($sformatf("rand.word%0d", i), got[i], sent[i]);
    begin
      int budget;
      budget = 50;
      while (!bus.idle && budget > 0) begin @(posedge clk); #1; budget--; end
      chk("rand.idle", bus.idle, 1'b1);
    end

    // Channel is free here with tx_seq=tx_ack=1 (an even number of launches).
    // ---------------- simultaneous push and pop at level 2 ----------------
    cyc(0, 1, 8'h10, 1); exp5("pp1", 1, bus.tx_value, 1, 1, 0);
    cyc(0, 1, 8'h20, 1); exp5("pp2", 1, 8'h10, 0, 1, 0);
    cyc(0, 1, 8'h30, 1); exp5("pp3", 1, 8'h10, 0, 2, 0);
    cyc(0, 1, 8'h40, 0); exp5("pp4", 1, 8'h20, 1, 2, 0);
    cyc(0, 0, 8'h00, 1); exp5("pp5", 1, 8'h30, 0, 1, 0);
    cyc(0, 0, 8'h00, 0); exp5("pp6", 1, 8'h40, 1, 0, 0);
    cyc(0, 0, 8'h00, 1); exp5("pp7", 1, 8'h40, 1, 0, 1);

    // ---------------- reset with a transfer in flight ---------------------
    cyc(0, 1, 8'h3C, 1); exp5("rm1", 1, 8'h40, 1, 1, 0);
    cyc(0, 1, 8'h11, 1); exp5("rm2", 1, 8'h3C, 0, 1, 0);
    cyc(0, 1, 8'h22, 1); exp5("rm3", 1, 8'h3C, 0, 2, 0);
    cyc(1, 0, 8'h00, 1); exp5("rm_rst", 1, 8'h3C, 0, 0, 0);
    cyc(0, 1, 8'h77, 1); exp5("rm_push", 1, 8'h3C, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 8'h00, 1); exp5($sformatf("rm_wait%0d", k), 1, 8'h3C, 0, 1, 0);
    end
    cyc(0, 0, 8'h00, 0); exp5("rm_launch", 1, 8'h77, 1, 0, 0);
    cyc(0, 0, 8'h00, 1); exp5("rm_done", 1, 8'h77, 1, 0, 1);

    // ---------------- reset with channel free and FIFO full ---------------
    cyc(0, 1, 8'h50, 1); exp5("rf1", 1, 8'h77, 1, 1, 0);
    cyc(0, 1, 8'h61, 1); exp5("rf2", 1, 8'h50, 0, 1, 0);
    cyc(0, 1, 8'h62, 1); exp5("rf3", 1, 8'h50, 0, 2, 0);
    cyc(0, 1, 8'h63, 1); exp5("rf4", 1, 8'h50, 0, 3, 0);
    cyc(0, 1, 8'h64, 1); exp5("rf5", 0, 8'h50, 0, 4, 0);
    cyc(1, 0, 8'h00, 0); exp5("rf_rst", 1, 8'h50, 0, 0, 1);
    cyc(0, 1, 8'h99, 0); exp5("rf_push", 1, 8'h50, 0, 1, 0);
    cyc(0, 0, 8'h00, 0); exp5("rf_launch", 1, 8'h99, 1, 0, 0);
    cyc(0, 0, 8'h00, 1); exp5("rf_done", 1, 8'h99, 1, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard bound on total run time.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
